// File: rtl/fetch_stage.sv
// IF-stage front end: PC register, HLT freeze, decode redirects and a 2-bit BHT + BTB predictor.
// Define FETCH_BHT_EN to build the predictor; otherwise fetch is static not-taken with no predictor storage.
module fetch_stage #(
  parameter int unsigned BHT_IDX_W = 3,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_stall,
  input  logic        mispredicted,
  input  logic [15:0] actual_target,
  input  logic        ID_update_en,
  input  logic [15:0] ID_PC_curr,
  input  logic        ID_actual_taken,
  input  logic [15:0] ID_actual_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] PC_curr,
  output logic [15:0] PC_next,
  output logic [15:0] instr_out,
  output logic        predicted_taken,
  output logic [15:0] predicted_target,
  output logic        halted
);

  logic [15:0] pc_q;
  logic        halted_q;
  logic [3:0]  opcode;
  logic        is_branch;
  logic        is_hlt;

  assign opcode    = imem_data[15:12];
  assign is_branch = (opcode == 4'b1100) || (opcode == 4'b1101);
  assign is_hlt    = (opcode == 4'b1111);

  assign imem_addr = pc_q;
  assign PC_curr   = pc_q;
  assign PC_next   = pc_q + 16'd2;
  assign instr_out = imem_data;
  assign halted    = halted_q;

`ifdef FETCH_BHT_EN
  localparam int unsigned ENTRIES = 1 << BHT_IDX_W;
  localparam int unsigned TAG_W   = 15 - BHT_IDX_W;

  logic [1:0]           bht        [ENTRIES];
  logic [ENTRIES-1:0]   btb_valid;
  logic [TAG_W-1:0]     btb_tag    [ENTRIES];
  logic [15:0]          btb_target [ENTRIES];
  logic [BHT_IDX_W-1:0] fetch_idx;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0]     fetch_tag;
  logic [TAG_W-1:0]     upd_tag;
  logic                 unused;

  assign fetch_idx = pc_q[BHT_IDX_W:1];
  assign fetch_tag = pc_q[15:BHT_IDX_W+1];
  assign upd_idx   = ID_PC_curr[BHT_IDX_W:1];
  assign upd_tag   = ID_PC_curr[15:BHT_IDX_W+1];
  assign unused    = ^{imem_data[11:0], ID_PC_curr[0]};

  // Reads see the pre-update entry; a same-cycle update is visible on the next fetch.
  assign predicted_taken  = is_branch && bht[fetch_idx][1] && btb_valid[fetch_idx] &&
                            (btb_tag[fetch_idx] == fetch_tag);
  assign predicted_target = predicted_taken ? btb_target[fetch_idx] : PC_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
      btb_valid <= '0;
    end else if (ID_update_en) begin
      if (ID_actual_taken) begin
        if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
        btb_valid[upd_idx] <= 1'b1;
      end else if (bht[upd_idx] != 2'b00) begin
        bht[upd_idx] <= bht[upd_idx] - 2'd1;
      end
    end
  end

  // Tag and target are qualified by btb_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (ID_update_en && ID_actual_taken) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= ID_actual_target;
    end
  end
`else
  logic unused;

  assign unused = ^{imem_data[11:0], is_branch, ID_update_en, ID_PC_curr,
                    ID_actual_taken, ID_actual_target};
  assign predicted_taken  = 1'b0;
  assign predicted_target = PC_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else if (mispredicted) begin
      pc_q     <= actual_target;
      halted_q <= 1'b0;
    end else if (PC_stall) begin
      pc_q <= pc_q;
    end else if (halted_q || is_hlt) begin
      halted_q <= 1'b1;
    end else begin
      pc_q <= predicted_target;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage; expectations track whether FETCH_BHT_EN is defined.
module tb_fetch_stage;

`ifdef FETCH_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        PC_stall;
  logic        mispredicted;
  logic [15:0] actual_target;
  logic        ID_update_en;
  logic [15:0] ID_PC_curr;
  logic        ID_actual_taken;
  logic [15:0] ID_actual_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] PC_curr;
  logic [15:0] PC_next;
  logic [15:0] instr_out;
  logic        predicted_taken;
  logic [15:0] predicted_target;
  logic        halted;

  typedef struct packed {
    logic [15:0] pc;
    logic        halted;
    logic        ptaken;
    logic [15:0] ptarget;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .PC_stall(PC_stall), .mispredicted(mispredicted),
    .actual_target(actual_target), .ID_update_en(ID_update_en), .ID_PC_curr(ID_PC_curr),
    .ID_actual_taken(ID_actual_taken), .ID_actual_target(ID_actual_target),
    .imem_addr(imem_addr), .imem_data(imem_data), .PC_curr(PC_curr), .PC_next(PC_next),
    .instr_out(instr_out), .predicted_taken(predicted_taken),
    .predicted_target(predicted_target), .halted(halted)
  );

  // Program image: branch at 0x0008, HLT at 0x000C, ADD everywhere else.
  assign imem_data = (imem_addr == 16'h0008) ? 16'hC000 :
                     (imem_addr == 16'h000C) ? 16'hF000 : 16'h0123;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; PC_stall = 0; mispredicted = 0; actual_target = 0;
    ID_update_en = 0; ID_PC_curr = 0; ID_actual_taken = 0; ID_actual_target = 0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (PC_curr !== 16'h0000 || halted !== 1'b0 || imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async: pc=%h halted=%b addr=%h expected pc=0000 halted=0 addr=0000",
               PC_curr, halted, imem_addr);
    end
    tick();
    checks++;
    if (PC_curr !== 16'h0000 || predicted_taken !== 1'b0 || PC_next !== 16'h0002) begin
      errors++;
      $display("FAIL reset_hold: pc=%h taken=%b next=%h expected pc=0000 taken=0 next=0002",
               PC_curr, predicted_taken, PC_next);
    end
    rst = 1'b1;
  endtask

  task automatic test_sequential();
    exp_t e;
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back('{pc: 16'(2*i), halted: 1'b0, ptaken: 1'b0, ptarget: 16'(2*i+2)});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (PC_curr !== e.pc || halted !== e.halted || predicted_taken !== e.ptaken ||
          predicted_target !== e.ptarget || instr_out !== 16'h0123) begin
        errors++;
        $display("FAIL sequential: pc=%h halted=%b taken=%b target=%h instr=%h expected pc=%h halted=%b taken=%b target=%h instr=0123",
                 PC_curr, halted, predicted_taken, predicted_target, instr_out,
                 e.pc, e.halted, e.ptaken, e.ptarget);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      PC_stall = (i < 2);
      if (i < 2) exp_q.push_back('{pc: 16'h0004, halted: 1'b0, ptaken: 1'b0, ptarget: 16'h0006});
      else       exp_q.push_back('{pc: 16'h0006, halted: 1'b0, ptaken: 1'b0, ptarget: 16'h0008});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (PC_curr !== e.pc || halted !== e.halted || predicted_taken !== e.ptaken ||
          predicted_target !== e.ptarget) begin
        errors++;
        $display("FAIL stall_%0d: pc=%h halted=%b taken=%b target=%h expected pc=%h halted=%b taken=%b target=%h",
                 i, PC_curr, halted, predicted_taken, predicted_target,
                 e.pc, e.halted, e.ptaken, e.ptarget);
      end
    end
    PC_stall = 1'b0;
  endtask

  task automatic test_predict_taken();
    exp_t e;
    // Train 0x0008 twice (01 -> 10 -> 11) while fetch is held at 0x0006.
    PC_stall = 1; ID_update_en = 1; ID_PC_curr = 16'h0008;
    ID_actual_taken = 1; ID_actual_target = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        PC_stall = 0; ID_update_en = 0;
      end
      case (i)
        0, 1: exp_q.push_back('{pc: 16'h0006, halted: 1'b0, ptaken: 1'b0, ptarget: 16'h0008});
        2: exp_q.push_back('{pc: 16'h0008, halted: 1'b0, ptaken: BHT_ON,
                             ptarget: BHT_ON ? 16'h0020 : 16'h000A});
        default: exp_q.push_back('{pc: BHT_ON ? 16'h0020 : 16'h000A, halted: 1'b0, ptaken: 1'b0,
                                   ptarget: BHT_ON ? 16'h0022 : 16'h000C});
      endcase
      tick();
      e = exp_q.pop_front();
      checks++;
      if (PC_curr !== e.pc || halted !== e.halted || predicted_taken !== e.ptaken ||
          predicted_target !== e.ptarget) begin
        errors++;
        $display("FAIL predict_taken_%0d: pc=%h halted=%b taken=%b target=%h expected pc=%h halted=%b taken=%b target=%h",
                 i, PC_curr, halted, predicted_taken, predicted_target,
                 e.pc, e.halted, e.ptaken, e.ptarget);
      end
    end
  endtask

  task automatic test_mispredict();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      mispredicted = (i == 0); PC_stall = (i == 0); actual_target = 16'h0040;
      if (i == 0) exp_q.push_back('{pc: 16'h0040, halted: 1'b0, ptaken: 1'b0, ptarget: 16'h0042});
      else        exp_q.push_back('{pc: 16'h0042, halted: 1'b0, ptaken: 1'b0, ptarget: 16'h0044});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (PC_curr !== e.pc || halted !== e.halted || predicted_taken !== e.ptaken ||
          predicted_target !== e.ptarget) begin
        errors++;
        $display("FAIL mispredict_%0d: pc=%h halted=%b taken=%b target=%h expected pc=%h halted=%b taken=%b target=%h",
                 i, PC_curr, halted, predicted_taken, predicted_target,
                 e.pc, e.halted, e.ptaken, e.ptarget);
      end
    end
    mispredicted = 0; PC_stall = 0;
  endtask

  // Counter walk on index 4 (0x0008) with an aliasing PC 0x0018, fetch held at the branch.
  task automatic test_counter_alias();
    typedef struct packed {
      logic [15:0] pc;
      logic        taken;
      logic [15:0] target;
      logic        exp_taken;
      logic [15:0] exp_target;
    } upd_t;
    upd_t tbl[11];
    exp_t e;
    tbl[0]  = '{16'h0008, 1'b0, 16'h0000, BHT_ON, 16'h0020};
    tbl[1]  = '{16'h0008, 1'b0, 16'h0000, 1'b0,   16'h0000};
    tbl[2]  = '{16'h0018, 1'b1, 16'h0030, 1'b0,   16'h0000};
    tbl[3]  = '{16'h0018, 1'b1, 16'h0030, 1'b0,   16'h0000};
    tbl[4]  = '{16'h0008, 1'b1, 16'h0024, BHT_ON, 16'h0024};
    tbl[5]  = '{16'h0008, 1'b0, 16'h0000, BHT_ON, 16'h0024};
    tbl[6]  = '{16'h0008, 1'b0, 16'h0000, 1'b0,   16'h0000};
    tbl[7]  = '{16'h0008, 1'b0, 16'h0000, 1'b0,   16'h0000};
    tbl[8]  = '{16'h0008, 1'b0, 16'h0000, 1'b0,   16'h0000};
    tbl[9]  = '{16'h0008, 1'b1, 16'h0024, 1'b0,   16'h0000};
    tbl[10] = '{16'h0008, 1'b1, 16'h0024, BHT_ON, 16'h0024};

    mispredicted = 1; actual_target = 16'h0008;
    tick();
    mispredicted = 0; PC_stall = 1;
    for (int i = 0; i < 11; i++) begin
      ID_update_en = 1; ID_PC_curr = tbl[i].pc;
      ID_actual_taken = tbl[i].taken; ID_actual_target = tbl[i].target;
      if (i == 0) begin
        #1;
        checks++;
        if (predicted_taken !== BHT_ON) begin
          errors++;
          $display("FAIL same_cycle_read: taken=%b expected %b", predicted_taken, BHT_ON);
        end
      end
      exp_q.push_back('{pc: 16'h0008, halted: 1'b0, ptaken: tbl[i].exp_taken,
                        ptarget: tbl[i].exp_taken ? tbl[i].exp_target : 16'h000A});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (PC_curr !== e.pc || halted !== e.halted || predicted_taken !== e.ptaken ||
          predicted_target !== e.ptarget) begin
        errors++;
        $display("FAIL counter_alias_%0d: pc=%h halted=%b taken=%b target=%h expected pc=%h halted=%b taken=%b target=%h",
                 i, PC_curr, halted, predicted_taken, predicted_target,
                 e.pc, e.halted, e.ptaken, e.ptarget);
      end
    end
    ID_update_en = 0; PC_stall = 0;
  endtask

  task automatic test_halt();
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      mispredicted = (i == 0) || (i == 7);
      actual_target = (i == 0) ? 16'h000C : 16'h0010;
      if (i == 0)      exp_q.push_back('{pc: 16'h000C, halted: 1'b0, ptaken: 1'b0, ptarget: 16'h000E});
      else if (i < 7)  exp_q.push_back('{pc: 16'h000C, halted: 1'b1, ptaken: 1'b0, ptarget: 16'h000E});
      else if (i == 7) exp_q.push_back('{pc: 16'h0010, halted: 1'b0, ptaken: 1'b0, ptarget: 16'h0012});
      else             exp_q.push_back('{pc: 16'h0012, halted: 1'b0, ptaken: 1'b0, ptarget: 16'h0014});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (PC_curr !== e.pc || halted !== e.halted || predicted_taken !== e.ptaken ||
          predicted_target !== e.ptarget) begin
        errors++;
        $display("FAIL halt_%0d: pc=%h halted=%b taken=%b target=%h expected pc=%h halted=%b taken=%b target=%h",
                 i, PC_curr, halted, predicted_taken, predicted_target,
                 e.pc, e.halted, e.ptaken, e.ptarget);
      end
    end
    mispredicted = 0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    mispredicted = 1; actual_target = 16'h0030;
    exp_q.push_back('{pc: 16'h0030, halted: 1'b0, ptaken: 1'b0, ptarget: 16'h0032});
    tick();
    mispredicted = 0;
    e = exp_q.pop_front();
    checks++;
    if (PC_curr !== e.pc || halted !== e.halted) begin
      errors++;
      $display("FAIL reset_setup: pc=%h halted=%b expected pc=%h halted=%b",
               PC_curr, halted, e.pc, e.halted);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (PC_curr !== 16'h0000 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_midcycle: pc=%h halted=%b expected pc=0000 halted=0", PC_curr, halted);
    end
    #2 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mispredicted = (i == 0); actual_target = 16'h0008;
      if (i == 0) exp_q.push_back('{pc: 16'h0008, halted: 1'b0, ptaken: 1'b0, ptarget: 16'h000A});
      else        exp_q.push_back('{pc: 16'h000A, halted: 1'b0, ptaken: 1'b0, ptarget: 16'h000C});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (PC_curr !== e.pc || halted !== e.halted || predicted_taken !== e.ptaken ||
          predicted_target !== e.ptarget) begin
        errors++;
        $display("FAIL post_reset_%0d: pc=%h halted=%b taken=%b target=%h expected pc=%h halted=%b taken=%b target=%h",
                 i, PC_curr, halted, predicted_taken, predicted_target,
                 e.pc, e.halted, e.ptaken, e.ptarget);
      end
    end
    mispredicted = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_predict_taken();
    test_mispredict();
    test_counter_alias();
    test_halt();
    test_async_reset();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
